// File: rtl/stream_req_gen.sv
// stream_req_gen: per-stream prefetch request generator.
//
// Software starts a stream with {sid, first line address, length}. Every
// running stream with credit is eligible. A round-robin arbiter picks one
// stream per cycle and loads a single output register with {sid, line addr}.
// Each stream is throttled by a credit count of free L2 slots. The consumer
// returns these credits one at a time.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_cfg_v/i_cfg_r             stream start handshake (ready = stream idle)
//   i_cfg_sid/i_cfg_ea/i_cfg_len  stream id, first line address, line count
//   i_crd_v/i_crd_sid           one freed L2 slot for a stream (always taken)
//   o_req_v/o_req_r             request handshake towards tag-issue
//   o_req_sid/o_req_ea          request stream id and line address
//   o_err                       sticky credit-overflow flag
//   o_stat_issued               issued-request counter (only with
//                               STREAM_REQ_GEN_STATS_EN defined)
//
// Optional feature macro: STREAM_REQ_GEN_STATS_EN

// One stream: address/length walker plus credit counter.
module stream_req_lane #(
  parameter int addr_width = 64,
  parameter int len_width  = 32,
  parameter int win_width  = 5,
  parameter int crd_max    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_ld,
  input  logic [addr_width-1:0] cfg_ea,
  input  logic [len_width-1:0]  cfg_len,
  input  logic                  gnt,
  input  logic                  ret,
  output logic                  active,
  output logic                  elig,
  output logic [addr_width-1:0] ea,
  output logic                  err_set
);
  logic [len_width-1:0] remain;
  logic [win_width-1:0] crd;
  logic                 crd_full;

  assign crd_full = (crd == win_width'(crd_max));
  assign elig     = active & (crd != '0);
  // A return to a full window is dropped. A same-cycle grant makes room for it.
  assign err_set  = ret & ~gnt & crd_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      ea     <= '0;
      remain <= '0;
      crd    <= win_width'(crd_max);
    end else begin
      // cfg only lands on an idle stream and grants only hit running ones,
      // so the two never collide.
      if (cfg_ld) begin
        active <= 1'b1;
        ea     <= cfg_ea;
        remain <= cfg_len;
      end else if (gnt) begin
        ea     <= ea + addr_width'(1);
        remain <= remain - len_width'(1);
        if (remain == len_width'(1)) active <= 1'b0;
      end
      // crd is not reloaded on cfg: lines still in flight from an earlier
      // run keep their slots.
      if (gnt && !ret)
        crd <= crd - win_width'(1);
      else if (ret && !gnt && !crd_full)
        crd <= crd + win_width'(1);
    end
  end
endmodule

module stream_req_gen #(
  parameter int addr_width   = 64,
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int len_width    = 32,
  parameter int win          = 16,
  parameter int win_width    = $clog2(win + 1),
  parameter int l2_ncl_width = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_cfg_v,
  output logic                    i_cfg_r,
  input  logic [nstrms_width-1:0] i_cfg_sid,
  input  logic [addr_width-1:0]   i_cfg_ea,
  input  logic [len_width-1:0]    i_cfg_len,
  input  logic                    i_crd_v,
  input  logic [nstrms_width-1:0] i_crd_sid,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [nstrms_width-1:0] o_req_sid,
  output logic [addr_width-1:0]   o_req_ea,
  output logic                    o_err
`ifdef STREAM_REQ_GEN_STATS_EN
  ,
  output logic [31:0]             o_stat_issued
`endif
);
  // The window can never exceed the number of L2 slots a stream can address.
  localparam int win_cap = (win < (1 << l2_ncl_width)) ? win : (1 << l2_ncl_width);

  logic [nstrms-1:0]                 active, elig, err_set;
  logic [nstrms-1:0]                 gnt_vec, ret_vec, ld_vec;
  logic [nstrms-1:0][addr_width-1:0] ea_vec;
  logic [nstrms_width-1:0]           rr, gnt_sid, idx;
  logic                              found, gnt, cfg_hs;

  assign i_cfg_r = ~active[i_cfg_sid];
  assign cfg_hs  = i_cfg_v & i_cfg_r;
  // The output register takes a new entry when it is empty or draining now.
  assign gnt     = found & (~o_req_v | o_req_r);

  always_comb begin
    gnt_vec = '0;
    ret_vec = '0;
    ld_vec  = '0;
    gnt_vec[gnt_sid]   = gnt;
    ret_vec[i_crd_sid] = i_crd_v;
    ld_vec[i_cfg_sid]  = cfg_hs & (i_cfg_len != '0);
  end

  // Round-robin: the first eligible stream at or after rr wins.
  always_comb begin
    found   = 1'b0;
    gnt_sid = '0;
    idx     = '0;
    for (int k = 0; k < nstrms; k++) begin
      idx = nstrms_width'((int'(rr) + k) % nstrms);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_sid = idx;
      end
    end
  end

  for (genvar s = 0; s < nstrms; s++) begin : g_lane
    stream_req_lane #(
      .addr_width (addr_width),
      .len_width  (len_width),
      .win_width  (win_width),
      .crd_max    (win_cap)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .cfg_ld  (ld_vec[s]),
      .cfg_ea  (i_cfg_ea),
      .cfg_len (i_cfg_len),
      .gnt     (gnt_vec[s]),
      .ret     (ret_vec[s]),
      .active  (active[s]),
      .elig    (elig[s]),
      .ea      (ea_vec[s]),
      .err_set (err_set[s])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_req_v   <= 1'b0;
      o_req_sid <= '0;
      o_req_ea  <= '0;
      o_err     <= 1'b0;
      rr        <= '0;
    end else begin
      if (gnt) begin
        o_req_v   <= 1'b1;
        o_req_sid <= gnt_sid;
        o_req_ea  <= ea_vec[gnt_sid];
        rr        <= (gnt_sid == nstrms_width'(nstrms - 1)) ? '0
                                                            : gnt_sid + nstrms_width'(1);
      end else if (o_req_r) begin
        o_req_v   <= 1'b0;
      end
      if (|err_set) o_err <= 1'b1;
    end
  end

`ifdef STREAM_REQ_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                  o_stat_issued <= '0;
    else if (o_req_v & o_req_r) o_stat_issued <= o_stat_issued + 32'd1;
  end
`endif
endmodule
